// File: rtl/key_pkg.sv
// Shared types for the key event controller: event codes, the 32-bit event word
// layout and the maximum supported key count.
package key_pkg;

  localparam int unsigned MAX_KEYS = 8;

  typedef enum logic [7:0] {
    KEY_PRESS   = 8'd1,
    KEY_RELEASE = 8'd2,
    KEY_REPEAT  = 8'd3
  } evt_code_t;

  typedef struct packed {
    evt_code_t   code;
    logic [7:0]  rsvd_hi;
    logic [4:0]  rsvd_lo;
    logic [2:0]  idx;
    logic [7:0]  snap;
  } key_evt_t;

  function automatic key_evt_t make_evt(evt_code_t code, logic [2:0] idx, logic [7:0] snap);
    key_evt_t e;
    e.code    = code;
    e.rsvd_hi = '0;
    e.rsvd_lo = '0;
    e.idx     = idx;
    e.snap    = snap;
    return e;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, debounce counter, stable level and
// single-cycle press/release edge flags.
module key_debounce_ch #(
  parameter int unsigned DebCycles = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = (DebCycles > 1) ? $clog2(DebCycles) : 1;

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic            pressed;

  assign pressed = ~sync2_q;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (pressed != stable_q) begin
      if (cnt_q == CntW'(DebCycles - 1)) begin
        stable_d = pressed;
        rise_d   = pressed;
        fall_d   = ~pressed;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser resets to the released (high) raw level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= key_n_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

endmodule

// File: rtl/key_event_ctrl.sv
// Key event front end: per-key debounce, pending-event arbiter, FWFT event FIFO
// with overflow flag and IRQ pulse. Optional auto-repeat under AUTO_REPEAT_EN.
module key_event_ctrl
  import key_pkg::*;
#(
  parameter int unsigned NKEYS      = 4,
  parameter int unsigned DEB_CYCLES = 1000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned REP_DELAY  = 50000,
  parameter int unsigned REP_RATE   = 10000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NKEYS-1:0]            key_n_i,
  input  logic                        rd_i,
  input  logic                        clr_ovf_i,
  output logic [31:0]                 evt_o,
  output logic                        evt_valid_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output logic                        overflow_o,
  output logic                        irq_o
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = AW + 1;

  logic [NKEYS-1:0]    stable, rise, fall;
  logic [MAX_KEYS-1:0] snap;

  for (genvar g = 0; g < NKEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DebCycles(DEB_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .key_n_i (key_n_i[g]),
      .stable_o(stable[g]),
      .rise_o  (rise[g]),
      .fall_o  (fall[g])
    );
  end

  always_comb begin
    snap             = '0;
    snap[NKEYS-1:0]  = stable;
  end

  // Pending events and arbiter
  logic [NKEYS-1:0] pend_press_q, pend_press_d, pend_rel_q, pend_rel_d;
  logic [NKEYS-1:0] clr_press, clr_rel;
  logic             push;
  logic [2:0]       gnt_idx;
  evt_code_t        gnt_code;
  logic [31:0]      evt_word;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RepMax = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  logic            rep_act_q, rep_act_d, rep_first_q, rep_first_d;
  logic            pend_rep_q, pend_rep_d;
  logic [2:0]      rep_idx_q, rep_idx_d;
  logic [RepW-1:0] rep_cnt_q, rep_cnt_d, rep_thr;
  logic            gnt_rep, press_gnt;
`else
  logic unused_rep_params;
  assign unused_rep_params = ^{REP_DELAY, REP_RATE};
`endif

  always_comb begin
    push      = 1'b0;
    gnt_idx   = '0;
    gnt_code  = KEY_PRESS;
    clr_press = '0;
    clr_rel   = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (!push) begin
        if (pend_rel_q[i]) begin
          push       = 1'b1;
          gnt_idx    = 3'(i);
          gnt_code   = KEY_RELEASE;
          clr_rel[i] = 1'b1;
        end else if (pend_press_q[i]) begin
          push         = 1'b1;
          gnt_idx      = 3'(i);
          gnt_code     = KEY_PRESS;
          clr_press[i] = 1'b1;
        end
      end
    end
`ifdef AUTO_REPEAT_EN
    gnt_rep = 1'b0;
    if (!push && pend_rep_q) begin
      push     = 1'b1;
      gnt_idx  = rep_idx_q;
      gnt_code = KEY_REPEAT;
      gnt_rep  = 1'b1;
    end
`endif
  end

  assign pend_press_d = (pend_press_q & ~clr_press) | rise;
  assign pend_rel_d   = (pend_rel_q & ~clr_rel) | fall;
  assign evt_word     = make_evt(gnt_code, gnt_idx, snap);

`ifdef AUTO_REPEAT_EN
  assign press_gnt = push && (gnt_code == KEY_PRESS);
  assign rep_thr   = rep_first_q ? RepW'(REP_DELAY - 1) : RepW'(REP_RATE - 1);

  // Counter reloads to 1 on the push it times from, so the next REPEAT lands
  // exactly REP_DELAY / REP_RATE cycles after that push.
  always_comb begin
    rep_act_d   = rep_act_q;
    rep_first_d = rep_first_q;
    rep_idx_d   = rep_idx_q;
    rep_cnt_d   = rep_cnt_q;
    pend_rep_d  = pend_rep_q;
    if (press_gnt) begin
      rep_act_d   = 1'b1;
      rep_first_d = 1'b1;
      rep_idx_d   = gnt_idx;
      rep_cnt_d   = RepW'(1);
      pend_rep_d  = 1'b0;
    end else if (rep_act_q && !snap[rep_idx_q]) begin
      rep_act_d  = 1'b0;
      pend_rep_d = 1'b0;
    end else if (gnt_rep) begin
      rep_first_d = 1'b0;
      rep_cnt_d   = RepW'(1);
      pend_rep_d  = 1'b0;
    end else if (rep_act_q && !pend_rep_q) begin
      if (rep_cnt_q >= rep_thr) begin
        pend_rep_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_act_q   <= 1'b0;
      rep_first_q <= 1'b0;
      rep_idx_q   <= '0;
      rep_cnt_q   <= '0;
      pend_rep_q  <= 1'b0;
    end else begin
      rep_act_q   <= rep_act_d;
      rep_first_q <= rep_first_d;
      rep_idx_q   <= rep_idx_d;
      rep_cnt_q   <= rep_cnt_d;
      pend_rep_q  <= pend_rep_d;
    end
  end
`endif

  // Event FIFO
  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d, irq_q;
  logic            empty, full, pop, push_ok, drop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(FIFO_DEPTH));
  assign pop     = rd_i && !empty;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_comb begin
    wptr_d = wptr_q + AW'(push_ok);
    rptr_d = rptr_q + AW'(pop);
    cnt_d  = cnt_q + CntW'(push_ok) - CntW'(pop);
    ovf_d  = ovf_q;
    if (clr_ovf_i) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= evt_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_press_q <= '0;
      pend_rel_q   <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      pend_press_q <= pend_press_d;
      pend_rel_q   <= pend_rel_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      irq_q        <= push_ok;
    end
  end

  assign evt_o       = empty ? 32'd0 : mem_q[rptr_q];
  assign evt_valid_o = !empty;
  assign count_o     = cnt_q;
  assign overflow_o  = ovf_q;
  assign irq_o       = irq_q;

endmodule
